// File: rtl/led_step_scheduler.sv
// led_step_scheduler
//   Produces the one-cycle advance pulse for the RGB colour-cycling LED block.
//   Two requesters compete for it: a debounced push-button (manual) and a
//   free-running period timer (automatic). Manual wins a tie. Every step is
//   followed by a hold-off window during which all requests are dropped.
//   A shadow of the LED block's 3-bit colour index is kept locally.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_raw      raw push-button, active-high, asynchronous to clk
//   auto_en      enables automatic stepping
//   step         one-cycle advance pulse to the LED block
//   step_src     source of the last step: 0 = auto, 1 = manual
//   color_idx    shadow colour index (resets to 7 like the LED block)
//   busy         high while in the hold-off window
//   auto_active  registered copy of the effective auto-run flag
//
// Build option
//   LED_LONG_PRESS_EN  when defined, a short press steps on release and a
//                      press held LONG_CYCLES toggles an internal auto latch.
module led_step_scheduler #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int AUTO_PERIOD     = 27000000,
  parameter int HOLDOFF_CYCLES  = 2700000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       auto_en,
  output logic       step,
  output logic       step_src,
  output logic [2:0] color_idx,
  output logic       busy,
  output logic       auto_active
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int AP_W = ($clog2(AUTO_PERIOD) < 1) ? 1 : $clog2(AUTO_PERIOD);
  localparam int HO_W = ($clog2(HOLDOFF_CYCLES) < 1) ? 1 : $clog2(HOLDOFF_CYCLES);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic {READY = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q;
  logic              sync1_q, sync2_q;
  logic              db_state_q, db_state_d;
  logic              db_prev_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [AP_W-1:0]   auto_cnt_q, auto_cnt_d;
  logic [HO_W-1:0]   hold_cnt_q;
  logic              step_q, step_src_q, auto_active_q;
  logic [2:0]        color_q;

  logic              man_req, auto_req, auto_run, fire;

  // Debounce: a differing level must persist DEBOUNCE_CYCLES edges; any
  // agreement in between restarts the count.
  always_comb begin
    db_cnt_d   = '0;
    db_state_d = db_state_q;
    if (sync2_q != db_state_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_state_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef LED_LONG_PRESS_EN
  localparam int LP_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_CYCLES);

  logic [LP_W-1:0] press_cnt_q, press_cnt_d;
  logic            auto_latch_q;
  logic            long_hit;

  // Press duration saturates at LONG_CYCLES; the release step is suppressed
  // once the press has reached that length.
  always_comb begin
    long_hit    = db_state_q && (press_cnt_q == LP_LAST);
    press_cnt_d = '0;
    if (db_state_q) begin
      press_cnt_d = (press_cnt_q == LP_MAX) ? press_cnt_q : press_cnt_q + LP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_cnt_q  <= '0;
      auto_latch_q <= 1'b0;
    end else begin
      press_cnt_q  <= press_cnt_d;
      auto_latch_q <= auto_latch_q ^ long_hit;
    end
  end

  assign man_req  = db_prev_q & ~db_state_q & (press_cnt_q != LP_MAX);
  assign auto_run = auto_en | auto_latch_q;
`else
  assign man_req  = db_state_q & ~db_prev_q;
  assign auto_run = auto_en;
`endif

  assign auto_req = (auto_cnt_q == AP_LAST);
  assign fire     = (state_q == READY) && (man_req || auto_req);

  // Timer only runs in READY with auto enabled; a step, HOLD or auto_run low
  // all restart it, so a dropped request is never replayed.
  always_comb begin
    auto_cnt_d = '0;
    if ((state_q == READY) && auto_run && !fire) begin
      auto_cnt_d = auto_cnt_q + AP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_state_q    <= 1'b0;
      db_prev_q     <= 1'b0;
      db_cnt_q      <= '0;
      auto_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      state_q       <= READY;
      step_q        <= 1'b0;
      step_src_q    <= 1'b0;
      color_q       <= 3'd7;
      auto_active_q <= 1'b0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      db_state_q    <= db_state_d;
      db_prev_q     <= db_state_q;
      db_cnt_q      <= db_cnt_d;
      auto_cnt_q    <= auto_cnt_d;
      auto_active_q <= auto_run;
      step_q        <= 1'b0;
      case (state_q)
        READY: begin
          // Manual checked first so it takes a coincident auto request.
          if (man_req || auto_req) begin
            step_q     <= 1'b1;
            step_src_q <= man_req;
            color_q    <= color_q + 3'd1;
            hold_cnt_q <= '0;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          // The step cycle is hold count 0, so HOLD spans HOLDOFF_CYCLES.
          if (hold_cnt_q == HO_LAST) begin
            state_q <= READY;
          end else begin
            hold_cnt_q <= hold_cnt_q + HO_W'(1);
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign step        = step_q;
  assign step_src    = step_src_q;
  assign color_idx   = color_q;
  assign busy        = (state_q == HOLD);
  assign auto_active = auto_active_q;

endmodule
